// File: rtl/multi_decade_down_counter.sv
// Two-digit BCD countdown timer: loads a preset, borrows ones->tens on each
// qualified tick, stops at 00 and flags expiry with a sticky flag and a one-clk pulse.
module multi_decade_down_counter #(
    parameter int N0 = 9,
    parameter int N1 = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [3:0] N0_V = 4'(N0);
    localparam logic [3:0] N1_V = 4'(N1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] ones_r, ones_s;
    logic [3:0] tens_r, tens_s;
    logic       running_r, running_s;
    logic       expired_r, expired_s;
    logic       done_r, done_s;
    logic       count_zero_s;

    assign count_zero_s = (ones_r == 4'd0) && (tens_r == 4'd0);

    // Next-state, next-digit and flag logic; priority is load > pause > start > tick.
    always_comb begin
        state_s = state_r;
        ones_s  = ones_r;
        tens_s  = tens_r;
        if (load) begin
            ones_s  = (load_ones > N0_V) ? N0_V : load_ones;
            tens_s  = (load_tens > N1_V) ? N1_V : load_tens;
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, PAUSED: begin
                    if (start && !pause) begin
                        state_s = count_zero_s ? EXPIRED : RUN;
                    end else begin
                        state_s = state_r;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_s = PAUSED;
                    end else if (tick) begin
                        if (ones_r != 4'd0) begin
                            ones_s = ones_r - 4'd1;
                        end else if (tens_r != 4'd0) begin
                            ones_s = N0_V;
                            tens_s = tens_r - 4'd1;
                        end else begin
                            ones_s = ones_r;
                        end
                        // Expiry is taken on the same edge that reaches 00.
                        if ((ones_s == 4'd0) && (tens_s == 4'd0)) begin
                            state_s = EXPIRED;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        state_s = RUN;
                    end
                end
                EXPIRED: begin
                    ones_s  = 4'd0;
                    tens_s  = 4'd0;
                    state_s = EXPIRED;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        running_s = (state_s == RUN);
        expired_s = (state_s == EXPIRED);
        done_s    = (state_s == EXPIRED) && (state_r != EXPIRED);
    end

    // State, digit and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            ones_r    <= 4'd0;
            tens_r    <= 4'd0;
            running_r <= 1'b0;
            expired_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            ones_r    <= ones_s;
            tens_r    <= tens_s;
            running_r <= running_s;
            expired_r <= expired_s;
            done_r    <= done_s;
        end
    end

    assign ones    = ones_r;
    assign tens    = tens_r;
    assign running = running_r;
    assign expired = expired_r;
    assign done    = done_r;

endmodule
